div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider that sits beside the execute stage and serves `div`/`divu` instructions, producing remainder and quotient for the HI/LO registers. It runs one restoring-division step per cycle under a four-state controller. The execute stage holds `start_i` and requests a pipeline stall until `ready_o` rises. A flush cancels an in-flight division through `annul_i`.

## Interface
Parameters: none (width fixed at 32 bits, 32 iterations).

- `clk`  in  1  — single clock; all state changes on its rising edge.
- `rst`  in  1  — reset, asynchronous and active-low.
- `signed_div_i`  in  1  — 1 = signed (`div`), 0 = unsigned (`divu`).
- `opdata1_i`  in  32  — dividend.
- `opdata2_i`  in  32  — divisor.
- `start_i`  in  1  — request; held high by execute until it consumes the result.
- `annul_i`  in  1  — cancel the current division (pipeline flush).
- `result_o`  out  64  — {remainder[63:32], quotient[31:0]}; 63:32 goes to HI and 31:0 goes to LO.
- `ready_o`  out  1  — result valid.

## Operation
- States: FREE, BYZERO, ON, END. Reset state is FREE. Reset values: `result_o`=0, `ready_o`=0, counter=0.
- FREE:
  - If `start_i`=1 and `annul_i`=0, latch the operands.
  - If divisor=0, go to BYZERO.
  - Otherwise go to ON with cnt=0.
  - In signed mode, a negative operand is latched as its two's-complement magnitude, and the sign of each operand is recorded.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- BYZERO: unconditionally go to END with `result_o`=0.
- ON:
  - If `annul_i`=1, go to FREE and discard the work.
  - Else, while cnt<32, do one step: T = {R[31:0], Q[31]} − D (33-bit). If T borrows, R={R[31:0], Q[31]}. Else R=T[31:0]. Then Q={Q[30:0], ~borrow}. cnt++.
  - Initial values: R=0, Q=|dividend|, D=|divisor|.
  - When cnt=32, finalize and go to END:
    - Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
    - Unsigned mode: results unchanged.
    - `result_o` takes the final value and `ready_o`=1.
- END:
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - When `start_i`=0, go to FREE with `result_o`=0 and `ready_o`=0.
  - `annul_i` is ignored in END.
- Operand inputs are ignored outside the FREE-accept cycle; changes during ON or END have no effect.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (natural two's-complement wrap, no trap).
- Division by zero gives `result_o`=0 in both modes.
- Asynchronous reset asserted in any state forces FREE and zeroes all outputs immediately.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- Normal division: edge 1 accepts `start_i`, edges 2–33 perform 32 steps, edge 34 finalizes. `ready_o` is high in the cycle after edge 34, i.e. 34 cycles after the accepting edge.
- Divide-by-zero: `ready_o` is high after edge 2.
- `start_i` and `annul_i` high on the same FREE cycle: the request is not accepted and the state stays FREE.
- `annul_i` during ON takes effect on the next edge; `ready_o` never rises for that request.
- Back-to-back requests: with `start_i` dropped for one cycle, END→FREE takes one edge and the next acceptance takes one more. Minimum request spacing is 36 cycles.
- If `start_i` stays high through the END→FREE edge, the block does not return to FREE; a new request requires `start_i` low for at least one edge.

## Test plan
- Unsigned 100 / 7: `result_o`={0x00000002, 0x0000000E}. `ready_o` rises exactly 34 cycles after acceptance and holds while `start_i`=1. It clears one cycle after `start_i` drops.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Unsigned mode with the same bits: quotient 0x7FFFFFFC, remainder 0x00000001.
- Divide by zero, both modes, dividend 0x12345678: `result_o`=0 and `ready_o` high 2 cycles after acceptance.
- Annul at cycle 10 of ON: state returns to FREE, `ready_o` stays 0. A following request 0xFFFFFFFF / 0x10 unsigned gives quotient 0x0FFFFFFF and remainder 0xF.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Changing `opdata1_i`/`opdata2_i` mid-ON does not alter the result.
- Drive `rst`=0 asynchronously at cycle 20 of ON: `ready_o` and `result_o` go to 0 without a clock edge. After release, a fresh 9 / 3 unsigned request gives {0, 3}.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: 32-bit restoring divider for div/divu, one quotient bit per cycle.
// result_o = {remainder, quotient}; ready_o holds while the requester keeps start_i high.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic        neg1_q, neg1_d, neg2_q, neg2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic [32:0] diff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Borrow in bit 32 means the shifted partial remainder is below the divisor.
    assign diff = {r_q, q_q[31]} - {1'b0, d_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        neg1_d   = neg1_q;
        neg2_d   = neg2_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    neg1_d  = signed_div_i & opdata1_i[31];
                    neg2_d  = signed_div_i & opdata2_i[31];
                    q_d     = neg1_d ? -opdata1_i : opdata1_i;
                    d_d     = neg2_d ? -opdata2_i : opdata2_i;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q != 6'd32) begin
                    r_d   = diff[32] ? {r_q[30:0], q_q[31]} : diff[31:0];
                    q_d   = {q_q[30:0], ~diff[32]};
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {neg1_q ? -r_q : r_q, (neg1_q ^ neg2_q) ? -q_q : q_q};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    div_unit dut (
        .clk(clk),
        .rst(rst),
        .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i),
        .start_i(start_i),
        .annul_i(annul_i),
        .result_o(result_o),
        .ready_o(ready_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == '0) return '0;
        x = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        y = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // One full request: accept, scramble operands, wait for ready, hold, release.
    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input string tag);
        int n;
        logic [63:0] e;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb.push_back(exp);
        tick();
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        n = 1;
        while (!ready_o && n < 60) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        e = sb.pop_front();
        check({tag, " result"}, result_o, e);
        repeat (3) tick();
        check({tag, " hold ready"}, 64'(ready_o), 64'd1);
        check({tag, " hold result"}, result_o, e);
        start_i = 1'b0;
        tick();
        check({tag, " release ready"}, 64'(ready_o), 64'd0);
        check({tag, " release result"}, result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        logic [31:0] a, b;
        logic s;
        int n;
        #2 rst = 1'b0;
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();

        run(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, "udiv 100/7");
        run(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, "sdiv -7/2");
        run(1'b0, 32'hFFFFFFF9, 32'h2, {32'h1, 32'h7FFFFFFC}, 34, "udiv F9/2");
        run(1'b0, 32'h12345678, 32'h0, 64'd0, 2, "udiv by0");
        run(1'b1, 32'h12345678, 32'h0, 64'd0, 2, "sdiv by0");

        // Annul at cycle 10 of ON.
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        tick();
        repeat (10) tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= ready_o;
        end
        check("annul never ready", 64'(seen), 64'd0);
        run(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 34, "udiv after annul");

        run(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, "sdiv min/-1");

        // start with annul in FREE must not be accepted.
        signed_div_i = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i = 1'b1;
        annul_i = 1'b1;
        repeat (3) tick();
        check("start+annul ready", 64'(ready_o), 64'd0);
        annul_i = 1'b0;
        run(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 34, "udiv 50/5");

        // Async reset at cycle 20 of ON.
        opdata1_i = 32'hDEADBEEF;
        opdata2_i = 32'd7;
        start_i = 1'b1;
        tick();
        repeat (20) tick();
        #2 rst = 1'b0;
        #1;
        check("rst on ready", 64'(ready_o), 64'd0);
        check("rst on result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        run(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, "udiv 9/3");

        // Async reset while ready is high.
        opdata1_i = 32'd9;
        opdata2_i = 32'd2;
        start_i = 1'b1;
        tick();
        n = 1;
        while (!ready_o && n < 60) begin
            tick();
            n++;
        end
        check("end pre ready", 64'(ready_o), 64'd1);
        check("end pre result", result_o, {32'd1, 32'd4});
        #2 rst = 1'b0;
        #1;
        check("rst end ready", 64'(ready_o), 64'd0);
        check("rst end result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        tick();

        repeat (6) begin
            s = 1'($urandom_range(1));
            a = $urandom;
            b = $urandom >> $urandom_range(31);
            run(s, a, b, model(s, a, b), (b == '0) ? 2 : 34, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
